// File: rtl/vga_pkg.sv
// Shared VGA timing constants, frame-buffer geometry and line-fetch FSM type.
package vga_pkg;

  // 640x480 visible area, 800x525 total raster
  localparam int HD   = 640;
  localparam int VD   = 480;
  localparam int HMAX = 799;
  localparam int VMAX = 524;

  // Source frame buffer is upscaled by SCALE in both directions
  localparam int FB_W  = 160;
  localparam int FB_H  = 120;
  localparam int SCALE = 4;

  // Memory bus widths: word address and RGB444 pixel
  localparam int ADDR_W = 15;
  localparam int PIX_W  = 12;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetchState_t;

endpackage

// File: rtl/vga_line_fetch_if.sv
// Read-request bus between the line fetcher (master) and frame-buffer memory (slave).
interface vga_line_fetch_if;
  import vga_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [PIX_W-1:0]  mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/vga_line_fetch_line_ram.sv
// Two line banks in one simple dual-port RAM; the bank bit is the address MSB.
// Contents are deliberately not reset.
module line_ram #(
  parameter int DEPTH = 160,
  parameter int WIDTH = 12,
  parameter int COL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wrEn,
  input  logic [COL_W:0]   i_wrAddr,
  input  logic [WIDTH-1:0] i_wrData,
  input  logic [COL_W:0]   i_rdAddr,
  output logic [WIDTH-1:0] o_rdData
);

  logic [WIDTH-1:0] r_mem [2][DEPTH];

  // Write port: one word into the addressed bank/column
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr[COL_W]][i_wrAddr[COL_W-1:0]] <= i_wrData;
    end
  end

  // Synchronous read port: data appears the clock after the address
  always_ff @(posedge clk) begin
    o_rdData <= r_mem[i_rdAddr[COL_W]][i_rdAddr[COL_W-1:0]];
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Double-buffered VGA line fetcher: while one bank is displayed (each source
// pixel repeated SCALE times), the next source row is read from memory into the
// other bank. Banks swap at the end of the last display line of each source row.
module vga_line_fetch #(
  parameter int FB_W  = vga_pkg::FB_W,
  parameter int FB_H  = vga_pkg::FB_H,
  parameter int SCALE = vga_pkg::SCALE,
  parameter int HD    = vga_pkg::HD,
  parameter int VD    = vga_pkg::VD,
  parameter int HMAX  = vga_pkg::HMAX,
  parameter int VMAX  = vga_pkg::VMAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pixel_tick,
  input  logic [9:0]              h_count,
  input  logic [9:0]              v_count,
  vga_line_fetch_if.master        memBus,
  output logic [11:0]             rgb,
  output logic                    fetch_busy,
  output logic                    underrun
);
  import vga_pkg::*;

  localparam int COL_W = $clog2(FB_W);
  localparam int ROW_W = $clog2(FB_H);

  fetchState_t        r_state;
  fetchState_t        w_nextState;
  logic [COL_W-1:0]   r_col;
  logic [ADDR_W-1:0]  r_memAddr;
  logic               r_fillBank;
  logic               r_activeBank;
  logic               r_armed;
  logic               r_underrun;
  logic               r_visible;

  logic               w_tickHd;
  logic               w_startRow0;
  logic               w_startRowN;
  logic               w_start;
  logic               w_swap;
  logic               w_ackValid;
  logic               w_lastAck;
  logic               w_visibleNow;
  logic [ROW_W-1:0]   w_startRow;
  logic [ADDR_W-1:0]  w_startBase;
  logic [COL_W-1:0]   w_rdCol;
  logic [11:0]        w_ramData;

  // Row-n starts are only honoured after a row-0 start, so a reset mid-frame
  // waits for the next vertical blank before fetching anything.
  assign w_tickHd    = pixel_tick && (h_count == 10'(HD));
  assign w_startRow0 = w_tickHd && (v_count == 10'(VD));
  assign w_startRowN = w_tickHd && r_armed && (int'(v_count) < VD - SCALE)
                       && ((int'(v_count) % SCALE) == 0);
  assign w_start     = w_startRow0 || w_startRowN;
  assign w_swap      = pixel_tick && (h_count == 10'(HMAX))
                       && ((v_count == 10'(VMAX))
                           || ((int'(v_count) < VD - 1)
                               && ((int'(v_count) % SCALE) == SCALE - 1)));
  assign w_ackValid  = memBus.mem_ack && (r_state == FETCH);
  assign w_lastAck   = w_ackValid && (r_col == COL_W'(FB_W - 1));
  assign w_visibleNow = (h_count < 10'(HD)) && (v_count < 10'(VD));

  // Source row to fetch, its base word address, and the display read column
  always_comb begin
    w_startRow  = '0;
    w_startBase = '0;
    w_rdCol     = '0;
    if (!w_startRow0) begin
      w_startRow = ROW_W'(int'(v_count) / SCALE + 1);
    end
    w_startBase = ADDR_W'(int'(w_startRow) * FB_W);
    if (w_visibleNow) begin
      w_rdCol = COL_W'(int'(h_count) / SCALE);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state: start only from IDLE, finish on the last column's ack
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_start)   w_nextState = FETCH;
      FETCH:   if (w_lastAck) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: a request is outstanding for the whole fetch
  always_comb begin
    memBus.mem_req = (r_state == FETCH);
    fetch_busy     = (r_state == FETCH);
  end

  // Fetch datapath: column counter, word address and target bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col      <= '0;
      r_memAddr  <= '0;
      r_fillBank <= 1'b0;
    end else if ((r_state == IDLE) && w_start) begin
      r_col      <= '0;
      r_memAddr  <= w_startBase;
      r_fillBank <= ~r_activeBank;
    end else if (w_ackValid) begin
      r_col     <= w_lastAck ? '0 : r_col + 1'b1;
      r_memAddr <= w_lastAck ? r_memAddr : r_memAddr + 1'b1;
    end
  end

  assign memBus.mem_addr = r_memAddr;

  // Bank swap, sticky underrun (a finishing ack on the swap cycle is on time), arming
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_activeBank <= 1'b0;
      r_underrun   <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      if (w_swap) begin
        r_activeBank <= ~r_activeBank;
        if ((r_state == FETCH) && !w_lastAck) begin
          r_underrun <= 1'b1;
        end
      end
      if (w_startRow0) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign underrun = r_underrun;

  // Visible flag delayed to line up with the synchronous RAM read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_visible <= 1'b0;
    end else begin
      r_visible <= w_visibleNow;
    end
  end

  // Blank outside the visible area
  always_comb begin
    rgb = 12'h000;
    if (r_visible) begin
      rgb = w_ramData;
    end
  end

  line_ram #(
    .DEPTH (FB_W),
    .WIDTH (12),
    .COL_W (COL_W)
  ) u_lineRam (
    .clk      (clk),
    .i_wrEn   (w_ackValid),
    .i_wrAddr ({r_fillBank, r_col}),
    .i_wrData (memBus.mem_rdata),
    .i_rdAddr ({r_activeBank, w_rdCol}),
    .o_rdData (w_ramData)
  );

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: row fetches, bank swap/display, delayed
// acks, underrun and reset mid-fetch. Memory returns addr[11:0] as pixel data.
module tb_vga_line_fetch;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_tick;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic [11:0] rgb;
  logic        fetch_busy;
  logic        underrun;

  int errorCount = 0;
  int checkCount = 0;

  vga_line_fetch_if bus ();

  vga_line_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick),
    .h_count    (h_count),
    .v_count    (v_count),
    .memBus     (bus.master),
    .rgb        (rgb),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Memory model data: pixel word equals low 12 bits of its address
  assign bus.mem_rdata = bus.mem_addr[11:0];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present timing inputs for one clock, then sample just after the edge
  task automatic applyStimulus(input logic tick, input int h, input int v);
    pixel_tick = tick;
    h_count    = 10'(h);
    v_count    = 10'(v);
    @(posedge clk);
    #1;
    pixel_tick = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    pixel_tick  = 1'b0;
    h_count     = '0;
    v_count     = '0;
    bus.mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req", 32'(bus.mem_req), 0);
    checkOutput("reset addr", 32'(bus.mem_addr), 0);
    checkOutput("reset busy", 32'(fetch_busy), 0);
    checkOutput("reset underrun", 32'(underrun), 0);
    checkOutput("reset rgb", 32'(rgb), 0);
    reset = 1'b0;

    // Row 0 fetch with an ack every cycle
    bus.mem_ack = 1'b1;
    applyStimulus(1'b1, HD, VD);
    for (int i = 0; i < FB_W; i++) begin
      checkOutput("row0 addr", 32'(bus.mem_addr), i);
      checkOutput("row0 req", 32'(bus.mem_req), 1);
      checkOutput("row0 busy", 32'(fetch_busy), 1);
      applyStimulus(1'b0, HD + 1, VD);
    end
    checkOutput("row0 done busy", 32'(fetch_busy), 0);
    checkOutput("row0 done req", 32'(bus.mem_req), 0);
    checkOutput("row0 underrun", 32'(underrun), 0);

    // Swap into row 0 and display it
    applyStimulus(1'b1, HMAX, VMAX);
    applyStimulus(1'b0, 0, 0);
    checkOutput("rgb h0", 32'(rgb), 32'h000);
    applyStimulus(1'b0, 3, 0);
    checkOutput("rgb h3", 32'(rgb), 32'h000);
    applyStimulus(1'b0, 4, 0);
    checkOutput("rgb h4", 32'(rgb), 32'h001);
    applyStimulus(1'b0, 8, 0);
    checkOutput("rgb h8", 32'(rgb), 32'h002);
    applyStimulus(1'b0, 639, 0);
    checkOutput("rgb h639", 32'(rgb), 32'h09F);
    applyStimulus(1'b0, 700, 0);
    checkOutput("rgb h700", 32'(rgb), 32'h000);
    applyStimulus(1'b0, 8, 500);
    checkOutput("rgb v500", 32'(rgb), 32'h000);

    // Row 1 fetch, then swap at line 3 and display row 1
    applyStimulus(1'b1, HD, 0);
    for (int i = 0; i < FB_W; i++) begin
      checkOutput("row1 addr", 32'(bus.mem_addr), 160 + i);
      applyStimulus(1'b0, HD + 1, 0);
    end
    checkOutput("row1 done busy", 32'(fetch_busy), 0);
    applyStimulus(1'b1, HMAX, 3);
    applyStimulus(1'b0, 8, 4);
    checkOutput("row1 rgb h8", 32'(rgb), 32'h0A2);

    // No start on the last row's line or off the row boundary
    applyStimulus(1'b1, HD, 476);
    checkOutput("v476 no req", 32'(bus.mem_req), 0);
    applyStimulus(1'b1, HD, 1);
    checkOutput("v1 no req", 32'(bus.mem_req), 0);

    // Row 2 fetch with every ack delayed three clocks
    bus.mem_ack = 1'b0;
    applyStimulus(1'b1, HD, 4);
    for (int i = 0; i < FB_W; i++) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput("slow req held", 32'(bus.mem_req), 1);
        checkOutput("slow addr held", 32'(bus.mem_addr), 320 + i);
        applyStimulus(1'b0, HD + 1, 4);
      end
      bus.mem_ack = 1'b1;
      applyStimulus(1'b0, HD + 1, 4);
      bus.mem_ack = 1'b0;
    end
    checkOutput("slow done busy", 32'(fetch_busy), 0);
    checkOutput("slow underrun", 32'(underrun), 0);
    applyStimulus(1'b1, HMAX, 7);
    applyStimulus(1'b0, 0, 8);
    checkOutput("row2 rgb col0", 32'(rgb), 32'h140);
    applyStimulus(1'b0, 320, 8);
    checkOutput("row2 rgb col80", 32'(rgb), 32'h190);
    applyStimulus(1'b0, 636, 8);
    checkOutput("row2 rgb col159", 32'(rgb), 32'h1DF);

    // Row 3 fetch stalled past its swap
    applyStimulus(1'b1, HD, 8);
    checkOutput("stall addr", 32'(bus.mem_addr), 480);
    applyStimulus(1'b0, HD + 1, 8);
    applyStimulus(1'b0, HD + 2, 8);
    checkOutput("stall underrun before", 32'(underrun), 0);
    checkOutput("stall addr held", 32'(bus.mem_addr), 480);
    applyStimulus(1'b1, HMAX, 11);
    checkOutput("stall underrun set", 32'(underrun), 1);
    checkOutput("stall still busy", 32'(fetch_busy), 1);
    bus.mem_ack = 1'b1;
    for (int n = 0; n < FB_W + 10 && fetch_busy; n++) begin
      applyStimulus(1'b0, 0, 11);
    end
    checkOutput("stall fetch finished", 32'(fetch_busy), 0);
    checkOutput("stall underrun sticky", 32'(underrun), 1);
    applyStimulus(1'b0, 8, 12);
    checkOutput("stall rgb in active bank", 32'(rgb), 32'h1E2);

    // Reset in the middle of a fetch
    applyStimulus(1'b1, HD, VD);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, HD + 1, VD);
    end
    checkOutput("mid addr col50", 32'(bus.mem_addr), 50);
    bus.mem_ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid reset req", 32'(bus.mem_req), 0);
    checkOutput("mid reset busy", 32'(fetch_busy), 0);
    checkOutput("mid reset underrun", 32'(underrun), 0);
    checkOutput("mid reset rgb", 32'(rgb), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    applyStimulus(1'b1, HD, 0);
    checkOutput("after reset v0 no req", 32'(bus.mem_req), 0);
    applyStimulus(1'b1, HD, 4);
    checkOutput("after reset v4 no req", 32'(bus.mem_req), 0);
    applyStimulus(1'b1, HD, VD);
    checkOutput("after reset v480 req", 32'(bus.mem_req), 1);
    checkOutput("after reset v480 addr", 32'(bus.mem_addr), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 SHALL have parameters (name, default, meaning): FB_W 160 source pixels per row; FB_H 120 source rows; SCALE 4 display pixels/lines per source pixel; HD 640; VD 480; HMAX 799; VMAX 524.
REQ-002 SHALL have ports: clk  in  1  system clock; reset  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: pixel_tick  in  1  one-clk pixel strobe; h_count  in  10  current column; v_count  in  10  current line.
REQ-004 SHALL have ports: mem_req  out  1  read request; mem_addr  out  15  word address; mem_ack  in  1  read accepted, data valid; mem_rdata  in  12  RGB444 word.
REQ-005 SHALL have ports: rgb  out  12  pixel colour {R,G,B}; fetch_busy  out  1  line fetch in progress; underrun  out  1  sticky late-fetch flag.

Function
REQ-006 SHALL hold two line banks of FB_W x 12 bits; display reads the active bank, fetch writes the inactive bank.
REQ-007 SHALL drive rgb one clk after h_count/v_count: active-bank word at column h_count/SCALE when h_count<HD and v_count<VD, else 12'h000.
REQ-008 SHALL start a fetch on pixel_tick && h_count==HD when v_count==VD (row 0) or when v_count<VD-SCALE and v_count%SCALE==0 (row v_count/SCALE+1).
REQ-009 SHALL ignore a start event while a fetch is in progress.
REQ-010 SHALL swap banks on pixel_tick && h_count==HMAX when v_count==VMAX or when v_count<VD-1 and v_count%SCALE==SCALE-1.
REQ-011 SHALL use FSM IDLE->FETCH on start event; FETCH->IDLE on the mem_ack of column FB_W-1; fetch_busy high exactly in FETCH.
REQ-012 SHALL set mem_addr = row*FB_W + col, col counting 0..FB_W-1.
REQ-013 SHALL hold mem_req high and mem_addr stable until mem_ack is sampled high; SHALL keep one request outstanding; mem_req MAY stay high into the next cycle with the next address.
REQ-014 SHALL write mem_rdata into inactive bank at col on the cycle mem_ack is high.
REQ-015 SHALL ignore mem_ack while mem_req is low.
REQ-016 SHALL set underrun if a swap occurs while in FETCH; underrun stays high until reset; the swap still happens and the fetch continues into the now-active bank.
REQ-017 SHALL treat a final mem_ack coinciding with a swap as complete (no underrun).
REQ-018 SHALL accept arbitrary mem_ack latency; the only requirement is fetch completion before the swap.

Reset
REQ-019 SHALL on reset: state IDLE, mem_req 0, mem_addr 0, col 0, active bank 0, rgb 12'h000, fetch_busy 0, underrun 0.
REQ-020 SHALL NOT reset line bank contents; pixels before the first completed fetch are undefined.
REQ-021 SHALL abandon any fetch in progress on reset, issue no further requests, and first fetch at the next v_count==VD start event.

Structure
REQ-022 SHALL take timing constants (HD, VD, HMAX, VMAX), FB_W, FB_H, SCALE and the FSM state type from shared package vga_pkg.
REQ-023 SHALL instantiate one sub-module line_ram: simple dual-port 2*FB_W x 12, synchronous read, bank bit as address MSB.

Verification
REQ-024 Reset, memory acks every cycle, v_count=480 h_count=640 tick -> mem_addr 0..159 issued in 160 consecutive clks, fetch_busy falls after ack of addr 159, underrun 0.
REQ-025 Fetch row 0 with mem_rdata=addr[11:0]; after swap at v_count=524 h_count=799 -> v_count=0: h_count 0..3 give rgb 12'h000, h_count 8 gives 12'h002, h_count 700 gives 12'h000.
REQ-026 Start at v_count=0 h_count=640 -> mem_addr 160..319 (row 1); start at v_count=476 -> no request.
REQ-027 mem_ack delayed 3 clks per word -> mem_req and mem_addr held stable during each wait; all 160 words written; underrun 0.
REQ-028 mem_ack withheld during a row-1 fetch past swap at v_count=3 h_count=799 -> underrun 1 and stays 1 until reset.
REQ-029 Assert reset mid-fetch at column 50 -> mem_req 0 within the same cycle; after release no request until v_count=480 h_count=640.
